// File: rtl/recip_trig_ctrl.sv
// Reciprocal trig controller: cosec/sec/cot of an integer-degree angle using a
// shared Sin unit for magnitude lookups and one iterative restoring divider.
module recip_trig_ctrl #(
  parameter int unsigned SIN_LAT   = 1,
  parameter int unsigned NUM_SCALE = 10000000,
  parameter int unsigned COT_SCALE = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] angle,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        res_neg,
  output logic        err,
  output logic        ovf,
  output logic [15:0] sin_angle,
  input  logic [15:0] sin_mag
);

  localparam int unsigned AW = 16;
  localparam int unsigned NW = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned LW = (SIN_LAT > 1) ? $clog2(SIN_LAT) : 1;

  localparam logic [1:0] OP_COSEC = 2'b00;
  localparam logic [1:0] OP_SEC   = 2'b01;
  localparam logic [1:0] OP_COT   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [2:0] {IDLE, LOOK_A, LOOK_B, DIV, DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   ang_q, ang_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   den_q, den_d;
  logic [NW-1:0]   quo_q, quo_d;
  logic [AW-1:0]   rem_q, rem_d;
  logic [AW-1:0]   result_q, result_d;
  logic            res_neg_q, res_neg_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   sin_angle_q, sin_angle_d;

  // Angle whose sine magnitude equals the cosine magnitude of a.
  function automatic logic [AW-1:0] comp_f(input logic [AW-1:0] a);
    return (a <= 16'd90) ? (16'd90 - a) : (16'd450 - a);
  endfunction

  logic          sin_neg_c, cos_neg_c, neg_c, lat_last_c, ge_c;
  logic [AW:0]   rem_sh_c, rem_sub_c;
  logic [NW-1:0] quo_nxt_c;

  // Sign of the result and one restoring-division step.
  always_comb begin
    sin_neg_c  = (ang_q > 16'd180);
    cos_neg_c  = (ang_q > 16'd90) && (ang_q < 16'd270);
    unique case (op_q)
      OP_COSEC: neg_c = sin_neg_c;
      OP_SEC:   neg_c = cos_neg_c;
      default:  neg_c = sin_neg_c ^ cos_neg_c;
    endcase
    lat_last_c = (lat_q == LW'(SIN_LAT - 1));
    rem_sh_c   = {rem_q, quo_q[NW-1]};
    ge_c       = (rem_sh_c >= {1'b0, den_q});
    rem_sub_c  = rem_sh_c - {1'b0, den_q};
    quo_nxt_c  = {quo_q[NW-2:0], ge_c};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ang_d       = ang_q;
    lat_d       = lat_q;
    cnt_d       = cnt_q;
    den_d       = den_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    result_d    = result_q;
    res_neg_d   = res_neg_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    sin_angle_d = sin_angle_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op;
          ang_d = angle;
          err_d = 1'b0;
          ovf_d = 1'b0;
          if (op == OP_RSVD || angle >= 16'd360) begin
            result_d  = '0;
            res_neg_d = 1'b0;
            err_d     = 1'b1;
            state_d   = DONE;
          end else begin
            lat_d       = '0;
            sin_angle_d = (op == OP_SEC) ? comp_f(angle) : angle;
            state_d     = LOOK_A;
          end
        end
      end
      LOOK_A: begin
        if (lat_last_c) begin
          den_d = sin_mag;
          if (op_q == OP_COT) begin
            lat_d       = '0;
            sin_angle_d = comp_f(ang_q);
            state_d     = LOOK_B;
          end else begin
            quo_d = NW'(NUM_SCALE);
            rem_d = '0;
            cnt_d = '0;
            if (sin_mag == '0) begin
              result_d  = 16'hFFFF;
              res_neg_d = 1'b0;
              err_d     = 1'b1;
              state_d   = DONE;
            end else begin
              state_d = DIV;
            end
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      LOOK_B: begin
        if (lat_last_c) begin
          quo_d = NW'(sin_mag) * NW'(COT_SCALE);
          rem_d = '0;
          cnt_d = '0;
          if (den_q == '0) begin
            result_d  = 16'hFFFF;
            res_neg_d = 1'b0;
            err_d     = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = DIV;
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      DIV: begin
        quo_d = quo_nxt_c;
        rem_d = ge_c ? rem_sub_c[AW-1:0] : rem_sh_c[AW-1:0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(31)) begin
          state_d = DONE;
          if (quo_nxt_c[NW-1:AW] != '0) begin
            result_d  = 16'hFFFF;
            ovf_d     = 1'b1;
            res_neg_d = neg_c;
          end else begin
            result_d  = quo_nxt_c[AW-1:0];
            res_neg_d = neg_c && (quo_nxt_c[AW-1:0] != '0);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // done trails the DONE state by one register so it coincides with busy dropping.
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      ang_q       <= '0;
      lat_q       <= '0;
      cnt_q       <= '0;
      den_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      result_q    <= '0;
      res_neg_q   <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sin_angle_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ang_q       <= ang_d;
      lat_q       <= lat_d;
      cnt_q       <= cnt_d;
      den_q       <= den_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      result_q    <= result_d;
      res_neg_q   <= res_neg_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sin_angle_q <= sin_angle_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign res_neg   = res_neg_q;
  assign err       = err_q;
  assign ovf       = ovf_q;
  assign sin_angle = sin_angle_q;

endmodule

// File: doc/recip_trig_ctrl.md
Name: recip_trig_ctrl

Overview:
- Sequential controller that computes cosec, sec and cot of an integer-degree angle.
- Time-multiplexes one external shared Sin unit and owns one iterative restoring divider, replacing per-function combinational dividers.
- Sits between the calculator's operation decoder and the Sin lookup.
- Fixed-point scaling:
  - sin magnitude is scaled by 10000.
  - Results are scaled by 1000, so cosec = 10000000/sin.

Parameters:
- SIN_LAT, 1, cycles from sin_angle change to a valid sin_mag; must be ≥1.
- NUM_SCALE, 10000000, numerator for cosec and sec.
- COT_SCALE, 1000, multiplier applied to cos for cot.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  function select: 00 cosec, 01 sec, 10 cot, 11 reserved.
- angle  in  16  unsigned degrees; valid range 0..359.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result and flags are valid.
- result  out  16  unsigned magnitude, scaled ×1000.
- res_neg  out  1  sign of result.
- err  out  1  divide-by-zero, reserved op, or angle ≥360.
- ovf  out  1  quotient exceeded 16'hFFFF.
- sin_angle  out  16  angle driven to the shared Sin unit.
- sin_mag  in  16  |sin(sin_angle)| ×10000, unsigned.

Behaviour:
- Reset values: busy=0, done=0, result=0, res_neg=0, err=0, ovf=0, sin_angle=0; state=IDLE. Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE → LOOK_A → [LOOK_B] → DIV → DONE → IDLE.
- IDLE:
  - On start=1, latch op and angle and clear err/ovf.
  - op=11 or angle≥360 → go to DONE with err=1, result=0.
  - Otherwise → LOOK_A.
  - result and flags hold their last values while in IDLE.
- Complement angle: c = (a≤90) ? 90−a : 450−a.
- LOOK_A:
  - sin_angle = a for cosec and cot; sin_angle = c for sec.
  - Wait SIN_LAT cycles, then capture sin_mag into reg A.
  - cot → LOOK_B; otherwise → DIV.
- LOOK_B (cot only):
  - sin_angle = c; wait SIN_LAT cycles; capture into reg B (cos magnitude).
- Denominator D = A.
- Numerator N:
  - cosec and sec: N = NUM_SCALE.
  - cot: N = B×COT_SCALE, at least 24 bits wide, zero-extended to 32.
- Divide-by-zero: D==0 on entry to DIV → skip the divider, result=16'hFFFF, err=1, go to DONE.
- DIV:
  - 32-bit/16-bit restoring division, one quotient bit per cycle, exactly 32 cycles.
  - Quotient >16'hFFFF → result=16'hFFFF, ovf=1; otherwise result = quotient[15:0] (truncation).
- Sign rules:
  - sin negative iff 180<a<360.
  - cos negative iff 90<a<270.
  - cosec takes the sin sign; sec takes the cos sign; cot = sin sign XOR cos sign.
  - res_neg is forced to 0 when result magnitude is 0 or err=1.
- DONE: done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE. start in DONE is ignored.
- Latency (start edge to done high), k = 1 for cosec/sec, 2 for cot:
  - Normal: k×SIN_LAT+33 cycles.
  - Zero denominator: k×SIN_LAT+1 cycles.
  - Range or op error: 1 cycle.
- start while busy is ignored and not queued. sin_angle holds its value outside the LOOK states.

Test Plan:
- Reset, then cosec at 30° (Sin model: sin(30)=5000), SIN_LAT=1 → done at cycle 34; result=2000, res_neg=0, err=0, ovf=0.
- sec at 60° (sin_angle driven to 30, returns 5000) → result=2000. sec at 120° → result=2000, res_neg=1.
- cot at 45° (both lookups return 7071) → exactly two LOOK phases; result=1000 at cycle 35. cot at 135° → res_neg=1.
- cosec at 0° (sin=0) → done at cycle 2, result=FFFF, err=1. angle=400 → err=1, result=0 at cycle 1. op=11 → err=1.
- cosec where the model returns sin=120 (quotient 83333) → result=FFFF, ovf=1, err=0. cosec at 210° (5000) → result=2000, res_neg=1.
- Assert rst_n low in the middle of DIV → outputs reset immediately, no done pulse. A start pulsed during busy → no second done; the first result is unaffected.
